// File: rtl/lut_1557.sv
// 4-input Boolean LUT with a registered copy and a rising-edge pulse.
// Optional feature: define LUT_1557_PROG_EN to make the truth table writable.
module lut_1557 #(
    parameter logic [15:0] INIT = 16'h0557
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  b,
    output logic        s,
    output logic        s_q,
    output logic        s_rise,
    input  logic        prog_we,
    input  logic [15:0] prog_data
);

    logic [15:0] table_bits;

`ifdef LUT_1557_PROG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            table_bits <= INIT;
        end else if (prog_we) begin
            table_bits <= prog_data;
        end
    end
`else
    // Program port is kept for drop-in compatibility but has no effect here.
    logic prog_unused;
    assign prog_unused = prog_we ^ (^prog_data);
    assign table_bits  = INIT;
`endif

    assign s = table_bits[b];

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= 1'b0;
            s_rise <= 1'b0;
        end else begin
            s_q    <= s;
            s_rise <= s & ~s_q;
        end
    end

endmodule

// File: tb/tb_lut_1557.sv
// Scoreboard bench for lut_1557: combinational sweep, directed clocked cases, random traffic.
module tb_lut_1557;

    localparam logic [15:0] INIT = 16'h0557;

    typedef struct packed {
        logic sq;
        logic rise;
    } exp_t;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  b = 4'd0;
    logic        s, s_q, s_rise;
    logic        prog_we = 1'b0;
    logic [15:0] prog_data = 16'd0;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned err_ones = 0;
    int unsigned err_zeros = 0;

    exp_t        sb_q[$];
    logic        mon_en = 1'b0;
    logic [15:0] model_tbl = INIT;
    logic        model_prev_sq = 1'b0;

    lut_1557 #(.INIT(16'h0557)) dut (
        .clk(clk),
        .rst(rst),
        .b(b),
        .s(s),
        .s_q(s_q),
        .s_rise(s_rise),
        .prog_we(prog_we),
        .prog_data(prog_data)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // Monitor: every registered output is compared against the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (sb_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL scoreboard_underflow: output seen at %0t with no expectation queued", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (s_q !== e.sq) begin
                    errors++;
                    $display("FAIL s_q @%0t: got %b expected %b", $time, s_q, e.sq);
                end
                checks++;
                if (s_rise !== e.rise) begin
                    errors++;
                    $display("FAIL s_rise @%0t: got %b expected %b", $time, s_rise, e.rise);
                end
            end
        end
    end

    task automatic check_s(input string name);
        logic want;
        want = model_tbl[b];
        checks++;
        if (s !== want) begin
            errors++;
            $display("FAIL %s: b=%0d s=%b expected %b", name, b, s, want);
        end
    endtask

    // One clock cycle, called at a negedge: drive, check s, queue the post-edge expectation.
    task automatic cycle(input logic r, input logic [3:0] bv, input logic we, input logic [15:0] data);
        exp_t e;
        rst       = r;
        b         = bv;
        prog_we   = we;
        prog_data = data;
        #1;
        check_s("s_clocked");
        e.sq   = r ? 1'b0 : model_tbl[bv];
        e.rise = e.sq & ~model_prev_sq;
        model_prev_sq = e.sq;
        sb_q.push_back(e);
        if (r) begin
            model_tbl = INIT;
        end else if (we) begin
`ifdef LUT_1557_PROG_EN
            model_tbl = data;
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        // Unclocked exhaustive sweep.
        for (int i = 0; i < 16; i++) begin
            logic want;
            b = 4'(i);
            #100;
            want = INIT[i];
            checks++;
            if (s !== want) begin
                errors++;
                if (want) err_ones++;
                else err_zeros++;
                $display("FAIL sweep: b=%0d s=%b expected %b", i, s, want);
            end
        end
        if (err_ones != 0 || err_zeros != 0)
            $display("sweep summary: expected-1 misses=%0d expected-0 misses=%0d", err_ones, err_zeros);

        b = 4'b0110; #10; check_s("b0110");
        b = 4'b0111; #10; check_s("b0111");
        b = 4'b1111; #10; check_s("b1111");
        b = 4'b0000; #10; check_s("b0000");

        clk_en = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        cycle(1, 4'b0011, 0, 16'h0);
        cycle(1, 4'b0011, 0, 16'h0);
        cycle(0, 4'b0011, 0, 16'h0);
        cycle(0, 4'b0001, 0, 16'h0);
        cycle(0, 4'b0001, 0, 16'h0);
        cycle(0, 4'b0001, 0, 16'h0);
        cycle(1, 4'b0001, 0, 16'h0);
        cycle(0, 4'b0100, 0, 16'h0);
        cycle(0, 4'b0100, 0, 16'h0);

        // Program path (ignored in the fixed-table build).
        cycle(0, 4'b0000, 1, 16'h8000);
        cycle(0, 4'b1111, 0, 16'h1234);
        cycle(0, 4'b0000, 0, 16'h0);
        cycle(1, 4'b0000, 0, 16'h0);
        cycle(0, 4'b0000, 0, 16'h0);
        cycle(1, 4'b0011, 1, 16'hFFFF);
        cycle(0, 4'b0011, 0, 16'h0);
        cycle(0, 4'b0011, 0, 16'h0);

        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0), 16'($urandom));
        end

        for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
